// File: rtl/bus_ro_snap_bank_pkg.sv
// rtl/bus_ro_snap_bank_pkg.sv - bus field layout and helpers shared by the snapshot bank
//
// Purpose: bus_in/bus_out field layout, bus widths, the default channel
//          stride and a helper that places a channel field in a bus word.
// Contents:
//   BUS_ADDR_WIDTH / BUS_DATA_WIDTH : bus address and data widths
//   BUS_STRIDE_DEFAULT              : default byte spacing between channels
//   bus_in_t  / BUS_IN_WIDTH        : {wr_data, wr_addr, rd_addr, we, re}
//   bus_out_t / BUS_OUT_WIDTH       : {rd_data, rd_ack, wr_ack, irq}
//   place_field()                   : mask to width, then shift left by offset
package bus_ro_snap_bank_pkg;

  localparam int BUS_ADDR_WIDTH     = 16;
  localparam int BUS_DATA_WIDTH     = 32;
  localparam int BUS_STRIDE_DEFAULT = 4;
  localparam int SNAP_CNT_WIDTH     = 16;

  typedef struct packed {
    logic [BUS_DATA_WIDTH-1:0] wr_data;
    logic [BUS_ADDR_WIDTH-1:0] wr_addr;
    logic [BUS_ADDR_WIDTH-1:0] rd_addr;
    logic                      we;
    logic                      re;
  } bus_in_t;

  typedef struct packed {
    logic [BUS_DATA_WIDTH-1:0] rd_data;
    logic                      rd_ack;
    logic                      wr_ack;
    logic                      irq;
  } bus_out_t;

  localparam int BUS_IN_WIDTH  = $bits(bus_in_t);
  localparam int BUS_OUT_WIDTH = $bits(bus_out_t);

  // Keep only the low 'width' bits of val, then move them up to 'offset'.
  function automatic logic [BUS_DATA_WIDTH-1:0] place_field(
    input logic [BUS_DATA_WIDTH-1:0] val,
    input int                        width,
    input int                        offset
  );
    logic [BUS_DATA_WIDTH-1:0] mask;
    mask = (width >= BUS_DATA_WIDTH) ? '1 : ((32'd1 << width) - 32'd1);
    return (val & mask) << offset;
  endfunction

endpackage

// File: rtl/bus_ro_snap_chan.sv
// rtl/bus_ro_snap_chan.sv - one shadowed read-only channel (k>0) of the snapshot bank
//
// Purpose: holds the shadow copy of one live channel value, loaded when the
//          bank's channel 0 is read; decodes its own address and returns the
//          shadow placed at OFFSET, zero when not addressed.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   rd_addr, re     : bus read address and read enable
//   snap            : load shadow from live on this edge
//   live            : live channel value
//   rd_data         : placed shadow value, 0 unless hit
//   hit             : this channel is being read this cycle
//   rd_pulse        : registered hit, high the cycle after the read
module bus_ro_snap_chan
  import bus_ro_snap_bank_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int OFFSET    = 0,
  parameter int CH_ADDR   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BUS_ADDR_WIDTH-1:0] rd_addr,
  input  logic                      re,
  input  logic                      snap,
  input  logic [DATAWIDTH-1:0]      live,
  output logic [BUS_DATA_WIDTH-1:0] rd_data,
  output logic                      hit,
  output logic                      rd_pulse
);

  localparam logic [BUS_ADDR_WIDTH-1:0] MY_ADDR = BUS_ADDR_WIDTH'(CH_ADDR);

  logic [DATAWIDTH-1:0] shadow_q, shadow_d;
  logic                 rd_pulse_q, rd_pulse_d;

  always_comb begin
    hit        = re && (rd_addr == MY_ADDR);
    shadow_d   = snap ? live : shadow_q;
    rd_pulse_d = hit;
    rd_data    = hit ? place_field(BUS_DATA_WIDTH'(shadow_q), DATAWIDTH, OFFSET) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= '0;
      rd_pulse_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  assign rd_pulse = rd_pulse_q;

endmodule

// File: rtl/bus_ro_snap_bank.sv
// rtl/bus_ro_snap_bank.sv - bank of read-only bus registers with coherent snapshot on channel 0 read
//
// Purpose: CHANNELS read-only registers at ADDR + k*STRIDE. Reading channel 0
//          returns its live value and, on the same edge, copies every other
//          channel into a shadow so later reads see one coherent set.
// Ports:
//   bus_clk, bus_reset_l : clock, asynchronous active-low reset
//   bus_in               : bus request (bus_in_t), only re/rd_addr are used
//   bus_out              : combinational read data and acks (bus_out_t),
//                          all zero when no bank address is read
//   in                   : live values, channel k at [k*DATAWIDTH +: DATAWIDTH]
//   rd_pulse             : one-hot registered read strobe per channel
// Option: BUS_RO_SNAP_SEQ_EN adds a 16-bit count of channel 0 reads, readable
//         at ADDR + CHANNELS*STRIDE in bits [15:0] (not shifted by OFFSET).
module bus_ro_snap_bank
  import bus_ro_snap_bank_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int OFFSET    = 0,
  parameter int CHANNELS  = 4,
  parameter int ADDR      = 0,
  parameter int STRIDE    = BUS_STRIDE_DEFAULT,
  parameter int REG       = 0
) (
  input  logic                          bus_clk,
  input  logic                          bus_reset_l,
  input  logic [BUS_IN_WIDTH-1:0]       bus_in,
  output logic [BUS_OUT_WIDTH-1:0]      bus_out,
  input  logic [CHANNELS*DATAWIDTH-1:0] in,
  output logic [CHANNELS-1:0]           rd_pulse
);

  localparam logic [BUS_ADDR_WIDTH-1:0] CH0_ADDR = BUS_ADDR_WIDTH'(ADDR);

  bus_in_t  bi;
  bus_out_t bo;

  logic [BUS_DATA_WIDTH-1:0] ch_data [CHANNELS];
  logic [CHANNELS-1:0]       ch_hit;
  logic                      hit0;
  logic                      rd_pulse0_q, rd_pulse0_d;
  logic                      seq_hit;
  logic [BUS_DATA_WIDTH-1:0] seq_data;
  logic                      unused_bus;

  assign bi = bus_in_t'(bus_in);
  // Write side of the bus is never acknowledged by this block.
  assign unused_bus = ^{bi.wr_data, bi.wr_addr, bi.we, 32'(REG)};

  // Channel 0: live value, and its read is the snapshot strobe.
  always_comb begin
    hit0        = bi.re && (bi.rd_addr == CH0_ADDR);
    rd_pulse0_d = hit0;
    ch_hit[0]   = hit0;
    ch_data[0]  = hit0 ? place_field(BUS_DATA_WIDTH'(in[DATAWIDTH-1:0]), DATAWIDTH, OFFSET) : '0;
  end

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) rd_pulse0_q <= 1'b0;
    else              rd_pulse0_q <= rd_pulse0_d;
  end

  assign rd_pulse[0] = rd_pulse0_q;

  for (genvar k = 1; k < CHANNELS; k++) begin : g_chan
    bus_ro_snap_chan #(
      .DATAWIDTH (DATAWIDTH),
      .OFFSET    (OFFSET),
      .CH_ADDR   (ADDR + k * STRIDE)
    ) u_chan (
      .clk      (bus_clk),
      .rst_n    (bus_reset_l),
      .rd_addr  (bi.rd_addr),
      .re       (bi.re),
      .snap     (hit0),
      .live     (in[k*DATAWIDTH +: DATAWIDTH]),
      .rd_data  (ch_data[k]),
      .hit      (ch_hit[k]),
      .rd_pulse (rd_pulse[k])
    );
  end

`ifdef BUS_RO_SNAP_SEQ_EN
  localparam logic [BUS_ADDR_WIDTH-1:0] SEQ_ADDR = BUS_ADDR_WIDTH'(ADDR + CHANNELS * STRIDE);

  logic [SNAP_CNT_WIDTH-1:0] snap_cnt_q, snap_cnt_d;

  // Reads return the pre-increment count; the counter wraps naturally.
  always_comb begin
    snap_cnt_d = hit0 ? snap_cnt_q + 16'd1 : snap_cnt_q;
    seq_hit    = bi.re && (bi.rd_addr == SEQ_ADDR);
    seq_data   = seq_hit ? {{(BUS_DATA_WIDTH-SNAP_CNT_WIDTH){1'b0}}, snap_cnt_q} : '0;
  end

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) snap_cnt_q <= '0;
    else              snap_cnt_q <= snap_cnt_d;
  end
`else
  assign seq_hit  = 1'b0;
  assign seq_data = '0;
`endif

  // Every source is already zero unless addressed, so a plain OR merges them.
  always_comb begin
    bo         = '0;
    bo.rd_data = seq_data;
    for (int k = 0; k < CHANNELS; k++) begin
      bo.rd_data = bo.rd_data | ch_data[k];
    end
    bo.rd_ack = (|ch_hit) | seq_hit;
    bo.wr_ack = 1'b0;
    bo.irq    = 1'b0;
  end

  assign bus_out = bo;

endmodule

// File: tb/tb_bus_ro_snap_bank.sv
// tb/tb_bus_ro_snap_bank.sv - self-checking bench for bus_ro_snap_bank
module tb_bus_ro_snap_bank;
  import bus_ro_snap_bank_pkg::*;

  localparam int DW  = 8;
  localparam int OFS = 8;
  localparam int CH  = 4;
  localparam int STR = 4;
  localparam logic [15:0] BASE     = 16'h0100;
  localparam logic [15:0] SEQ_A    = BASE + 16'(CH * STR);
  localparam logic [15:0] UNMAP_A  = BASE + 16'h0040;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  bus_in_t                  bi;
  bus_out_t                 bo;
  logic [BUS_IN_WIDTH-1:0]  bus_in;
  logic [BUS_OUT_WIDTH-1:0] bus_out;
  logic [CH*DW-1:0]         in_bus;
  logic [CH-1:0]            rd_pulse;

  logic [DW-1:0] live     [CH];
  logic [DW-1:0] shadow_m [CH];
  int            snap_m;

  int n_pass  = 0;
  int n_total = 0;

  assign bus_in = bi;
  assign bo     = bus_out_t'(bus_out);

  always_comb begin
    in_bus = '0;
    for (int k = 0; k < CH; k++) in_bus[k*DW +: DW] = live[k];
  end

  always #5 clk = ~clk;

  bus_ro_snap_bank #(
    .DATAWIDTH (DW),
    .OFFSET    (OFS),
    .CHANNELS  (CH),
    .ADDR      (int'(BASE)),
    .STRIDE    (STR),
    .REG       (1)
  ) dut (
    .bus_clk     (clk),
    .bus_reset_l (rst_n),
    .bus_in      (bus_in),
    .bus_out     (bus_out),
    .in          (in_bus),
    .rd_pulse    (rd_pulse)
  );

  // Reference model: expected response to a read of address a, then commit
  // the state change that read causes (snapshot, sequence count).
  function automatic void model_read(input logic [15:0] a, output logic [31:0] d,
                                     output logic ack, output logic [CH-1:0] pulse);
    int idx;
    idx   = -1;
    d     = 32'h0;
    ack   = 1'b0;
    pulse = '0;
    if (a >= BASE && a < BASE + 16'(CH * STR) && ((a - BASE) % STR) == 0)
      idx = int'(a - BASE) / STR;
    if (idx == 0) begin
      d = 32'(live[0]) << OFS;
    end else if (idx > 0) begin
      d = 32'(shadow_m[idx]) << OFS;
    end
`ifdef BUS_RO_SNAP_SEQ_EN
    if (a == SEQ_A) begin
      ack = 1'b1;
      d   = 32'(snap_m);
    end
`endif
    if (idx >= 0) begin
      ack   = 1'b1;
      pulse = CH'(1) << idx;
    end
    if (idx == 0) begin
      for (int k = 1; k < CH; k++) shadow_m[k] = live[k];
      snap_m = (snap_m + 1) % 65536;
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < CH; k++) shadow_m[k] = '0;
    snap_m = 0;
  endfunction

  // Drive one read starting just after a posedge; sample comb response
  // mid-cycle and rd_pulse just after the following edge.
  task automatic bus_read(input logic [15:0] a, output logic [31:0] d,
                          output logic ack, output logic [CH-1:0] pulse);
    bi.re      = 1'b1;
    bi.rd_addr = a;
    #1;
    d   = bo.rd_data;
    ack = bo.rd_ack;
    @(posedge clk);
    #1;
    pulse = rd_pulse;
    bi.re = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, ed;
    logic ack, eack;
    logic [CH-1:0] p, ep;
    bi     = '0;
    for (int k = 0; k < CH; k++) live[k] = '0;
    model_reset();
    rst_n = 1'b0;
    #12;
    n_total++; if (rd_pulse !== 4'b0000) $display("FAIL reset_rd_pulse got %b want 0000", rd_pulse); else n_pass++;
    n_total++; if (bus_out !== '0) $display("FAIL reset_bus_out got %h want 0", bus_out); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    live[2] = 8'h5C;
    model_read(BASE + 16'd8, ed, eack, ep);
    bus_read(BASE + 16'd8, d, ack, p);
    n_total++; if (d !== 32'h0) $display("FAIL reset_shadow2 got %h want 00000000", d); else n_pass++;
  endtask

  task automatic test_unsnapped_read();
    logic [31:0] d, ed;
    logic ack, eack;
    logic [CH-1:0] p, ep;
    logic [15:0] dead;
    dead    = 16'hDEAD;
    live[1] = dead[DW-1:0];
    model_read(BASE + 16'd4, ed, eack, ep);
    bus_read(BASE + 16'd4, d, ack, p);
    n_total++; if (d !== 32'h0) $display("FAIL unsnap_data got %h want 00000000", d); else n_pass++;
    n_total++; if (ack !== 1'b1) $display("FAIL unsnap_ack got %b want 1", ack); else n_pass++;
    n_total++; if (p !== 4'b0010) $display("FAIL unsnap_pulse got %b want 0010", p); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (rd_pulse !== 4'b0000) $display("FAIL unsnap_pulse_len got %b want 0000", rd_pulse); else n_pass++;
  endtask

  task automatic test_coherent_snapshot();
    logic [31:0] d, ed;
    logic ack, eack;
    logic [CH-1:0] p, ep;
    logic [31:0] want [CH];
    want[1] = 32'h1100; want[2] = 32'h2200; want[3] = 32'h3300;
    live[0] = 8'h00; live[1] = 8'h11; live[2] = 8'h22; live[3] = 8'h33;
    model_read(BASE, ed, eack, ep);
    bus_read(BASE, d, ack, p);
    n_total++; if (d !== 32'h0 || ack !== 1'b1) $display("FAIL snap_ch0 got %h/%b want 00000000/1", d, ack); else n_pass++;
    n_total++; if (p !== 4'b0001) $display("FAIL snap_ch0_pulse got %b want 0001", p); else n_pass++;
    for (int k = 0; k < CH; k++) live[k] = 8'hFF;
    for (int k = 1; k < CH; k++) begin
      model_read(BASE + 16'(k * STR), ed, eack, ep);
      bus_read(BASE + 16'(k * STR), d, ack, p);
      n_total++; if (d !== want[k]) $display("FAIL snap_ch%0d got %h want %h", k, d, want[k]); else n_pass++;
    end
  endtask

  task automatic test_offset_unmapped();
    logic [31:0] d, ed;
    logic ack, eack;
    logic [CH-1:0] p, ep;
    live[0] = 8'hA5;
    model_read(BASE, ed, eack, ep);
    bus_read(BASE, d, ack, p);
    n_total++; if (d !== 32'h0000A500) $display("FAIL offset_ch0 got %h want 0000A500", d); else n_pass++;
    model_read(UNMAP_A, ed, eack, ep);
    bus_read(UNMAP_A, d, ack, p);
    n_total++; if (d !== 32'h0 || ack !== 1'b0) $display("FAIL unmapped got %h/%b want 00000000/0", d, ack); else n_pass++;
    n_total++; if (p !== 4'b0000) $display("FAIL unmapped_pulse got %b want 0000", p); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, ed;
    logic ack, eack;
    logic [CH-1:0] p, ep;
    live[1] = 8'h01;
    model_read(BASE, ed, eack, ep);
    bus_read(BASE, d, ack, p);
    live[1] = 8'h02;
    model_read(BASE, ed, eack, ep);
    bus_read(BASE, d, ack, p);
    model_read(BASE + 16'd4, ed, eack, ep);
    bus_read(BASE + 16'd4, d, ack, p);
    n_total++; if (d !== 32'h00000200) $display("FAIL b2b_ch1 got %h want 00000200", d); else n_pass++;
  endtask

  task automatic test_write_ignored();
    bi.we      = 1'b1;
    bi.wr_addr = BASE + 16'd4;
    bi.wr_data = 32'hFFFF_FFFF;
    #1;
    n_total++; if (bo.rd_ack !== 1'b0 || bo.wr_ack !== 1'b0) $display("FAIL write_ack got rd %b wr %b want 0 0", bo.rd_ack, bo.wr_ack); else n_pass++;
    @(posedge clk);
    #1;
    bi.we = 1'b0;
    n_total++; if (rd_pulse !== 4'b0000) $display("FAIL write_pulse got %b want 0000", rd_pulse); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [31:0] d, ed;
    logic ack, eack;
    logic [CH-1:0] p, ep;
    for (int k = 0; k < CH; k++) live[k] = 8'h40 + 8'(k);
    model_read(BASE, ed, eack, ep);
    bus_read(BASE, d, ack, p);
    n_total++; if (p !== 4'b0001) $display("FAIL areset_pre_pulse got %b want 0001", p); else n_pass++;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (rd_pulse !== 4'b0000) $display("FAIL areset_pulse got %b want 0000", rd_pulse); else n_pass++;
    bi.re      = 1'b1;
    bi.rd_addr = BASE + 16'd8;
    #1;
    n_total++; if (bo.rd_data !== 32'h0 || bo.rd_ack !== 1'b1) $display("FAIL areset_shadow got %h/%b want 00000000/1", bo.rd_data, bo.rd_ack); else n_pass++;
    bi.re = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] d, ed;
    logic ack, eack;
    logic [CH-1:0] p, ep;
    logic [15:0] addrs [7];
    logic [15:0] a;
    addrs[0] = BASE; addrs[1] = BASE + 16'd4; addrs[2] = BASE + 16'd8;
    addrs[3] = BASE + 16'd12; addrs[4] = SEQ_A; addrs[5] = UNMAP_A; addrs[6] = BASE + 16'd2;
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < CH; k++) live[k] = DW'($urandom);
      a = (i % 3 == 0) ? BASE : addrs[$urandom_range(0, 6)];
      model_read(a, ed, eack, ep);
      bus_read(a, d, ack, p);
      n_total++;
      if (d !== ed || ack !== eack || p !== ep)
        $display("FAIL rand_%0d addr %h got %h/%b/%b want %h/%b/%b", i, a, d, ack, p, ed, eack, ep);
      else n_pass++;
    end
  endtask

  task automatic test_seq_reg();
    logic [31:0] d, ed;
    logic ack, eack;
    logic [CH-1:0] p, ep;
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef BUS_RO_SNAP_SEQ_EN
    bi.re      = 1'b1;
    bi.rd_addr = BASE;
    repeat (65537) @(posedge clk);
    #1;
    bi.re = 1'b0;
    for (int k = 1; k < CH; k++) shadow_m[k] = live[k];
    snap_m = (snap_m + 65537) % 65536;
    model_read(SEQ_A, ed, eack, ep);
    bus_read(SEQ_A, d, ack, p);
    n_total++; if (d !== 32'h00000001 || ack !== 1'b1) $display("FAIL seq_count got %h/%b want 00000001/1", d, ack); else n_pass++;
    n_total++; if (p !== 4'b0000) $display("FAIL seq_pulse got %b want 0000", p); else n_pass++;
`else
    model_read(SEQ_A, ed, eack, ep);
    bus_read(SEQ_A, d, ack, p);
    n_total++; if (ack !== 1'b0 || d !== 32'h0) $display("FAIL seq_absent got %h/%b want 00000000/0", d, ack); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_unsnapped_read();
    test_coherent_snapshot();
    test_offset_unmapped();
    test_back_to_back();
    test_write_ignored();
    test_async_reset();
    test_random();
    test_seq_reg();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
